// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: issue controller between decode and the ex stage.
//
// Accepts one decoded instruction per cycle over a valid/ready handshake,
// raises a one-cycle issue strobe to ex, and tracks the last two in-flight
// destinations so ex can forward operands instead of stalling. Branches are
// resolved over two blocked cycles, with an optional flush pulse. Loads and
// stores hold a memory request until ack, or until a timeout sets a sticky
// error.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   dec_valid_i / dec_ready_o     decode handshake
//   dec_rd_addr_i, dec_rs_addr_i  operand registers (rd is also a source)
//   dec_immf_i                    immediate form, rs not read
//   dec_ctrl_br/ld/st_i           instruction class
//   ex_issue_o                    issue strobe (same cycle as the handshake)
//   fwd_rd_sel_o, fwd_rs_sel_o    00 regfile, 01 ex result, 10 wb stage
//   ex_branch_en_i, flush_o       branch outcome in, flush pulse out
//   mem_req_o, mem_ack_i          memory handshake
//   err_o                         sticky memory timeout
//   busy_o                        controller not in RUN
//   dbg_state_o                   current FSM state, for observation only
//
// Handshake: a transfer happens in any cycle where dec_valid_i and
// dec_ready_o are both high. While dec_ready_o is low, decode keeps its
// instruction stable and nothing on the dec_* inputs is sampled.
module ex_issue_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  logic [REG_ADDR_W-1:0] dec_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] dec_rs_addr_i,
  input  logic                  dec_immf_i,
  input  logic                  dec_ctrl_br_i,
  input  logic                  dec_ctrl_ld_i,
  input  logic                  dec_ctrl_st_i,
  output logic                  ex_issue_o,
  output logic [1:0]            fwd_rd_sel_o,
  output logic [1:0]            fwd_rs_sel_o,
  input  logic                  ex_branch_en_i,
  output logic                  flush_o,
  output logic                  mem_req_o,
  input  logic                  mem_ack_i,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    BR_RES   = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  state_e                state_q;
  logic                  sb0_v_q, sb1_v_q;
  logic [REG_ADDR_W-1:0] sb0_a_q, sb1_a_q;
  // 1-based index of the current MEM_WAIT cycle, so the timeout fires on
  // exactly the MEM_TIMEOUT-th waiting cycle.
  logic [7:0]            cnt_q;
  logic                  err_q;
  logic                  issue;

  // Ready is gated by rst directly so it drops the moment reset asserts,
  // even though the state register already reads RUN during reset.
  assign flush_o     = (state_q == BR_RES) & ex_branch_en_i;
  assign dec_ready_o = rst & (state_q == RUN) & ~flush_o;
  assign issue       = dec_valid_i & dec_ready_o;
  assign ex_issue_o  = issue;
  assign mem_req_o   = (state_q == MEM_WAIT);
  assign busy_o      = (state_q != RUN);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  // Entry0 (issued last cycle) wins over entry1 (issued two cycles ago).
  always_comb begin
    fwd_rd_sel_o = 2'b00;
    fwd_rs_sel_o = 2'b00;
    if (sb0_v_q && sb0_a_q == dec_rd_addr_i)      fwd_rd_sel_o = 2'b01;
    else if (sb1_v_q && sb1_a_q == dec_rd_addr_i) fwd_rd_sel_o = 2'b10;
    if (!dec_immf_i) begin
      if (sb0_v_q && sb0_a_q == dec_rs_addr_i)      fwd_rs_sel_o = 2'b01;
      else if (sb1_v_q && sb1_a_q == dec_rs_addr_i) fwd_rs_sel_o = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      sb0_v_q <= 1'b0;
      sb1_v_q <= 1'b0;
      sb0_a_q <= '0;
      sb1_a_q <= '0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (issue) begin
            if (dec_ctrl_br_i) begin
              state_q <= BR_WAIT;
            end else if (dec_ctrl_ld_i || dec_ctrl_st_i) begin
              state_q <= MEM_WAIT;
              cnt_q   <= 8'd1;
            end
          end
        end
        BR_WAIT: state_q <= BR_RES;
        BR_RES:  state_q <= RUN;
        MEM_WAIT: begin
          // An ack on the final allowed cycle still counts as success.
          if (mem_ack_i) begin
            state_q <= RUN;
          end else if (cnt_q == 8'(MEM_TIMEOUT)) begin
            state_q <= RUN;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= RUN;
      endcase

      // The scoreboard is frozen while waiting on memory so the load's rd
      // is still in entry0 in the cycle after the ack.
      if (state_q != MEM_WAIT) begin
        sb1_v_q <= sb0_v_q;
        sb1_a_q <= sb0_a_q;
        sb0_v_q <= issue & ~(dec_ctrl_st_i | dec_ctrl_br_i);
        sb0_a_q <= dec_rd_addr_i;
      end
    end
  end

endmodule
